// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   SRC_A..SRC_D  : source indices, which are also the 2-bit mux select codes
//   RR_RESET_LAST : pointer value after reset, so that source 0 is searched first
//   slot_state_e  : output slot state; StFull is exactly out_valid
package rr_mux_arbiter_pkg;

    localparam logic [1:0] SRC_A         = 2'd0;
    localparam logic [1:0] SRC_B         = 2'd1;
    localparam logic [1:0] SRC_C         = 2'd2;
    localparam logic [1:0] SRC_D         = 2'd3;
    localparam logic [1:0] RR_RESET_LAST = SRC_D;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/mux_4x1.sv
// Combinational 4:1 word multiplexer.
//   a, b, c, d : source words
//   s1, s0     : select, s1 is the MSB ({s1,s0} = source index)
//   y          : selected word
module mux_4x1
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        unique case ({s1, s0})
            SRC_A:   y = a;
            SRC_B:   y = b;
            SRC_C:   y = c;
            SRC_D:   y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter plus single-entry capture slot in front of a 4:1 mux.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   req[3:0]            : per-source request (0=a, 1=b, 2=c, 3=d)
//   a, b, c, d          : source words
//   gnt[3:0]            : one-hot pulse, high for the cycle after source i is captured
//   s1, s0              : select code of the word held in the slot
//   out_data, out_valid : captured word and its valid flag
//   out_ready           : downstream accepts the slot contents
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // First requester after 'last' in rotating order; 'last' itself is searched last.
    function automatic logic [1:0] rr_pick(input logic [3:0] ereq, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && ereq[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       last_q, last_d;

    logic [3:0]       ereq;
    logic             slot_free;
    logic             capture;
    logic [1:0]       nxt;
    logic [WIDTH-1:0] mux_y;

    always_comb begin
        // A source granted last edge is masked so it cannot be captured twice.
        ereq      = req & ~gnt_q;
        slot_free = (state_q == StEmpty) | out_ready;
        nxt       = rr_pick(ereq, last_q);
        capture   = slot_free & (|ereq);
    end

    mux_4x1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .s1 (nxt[1]),
        .s0 (nxt[0]),
        .y  (mux_y)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        gnt_d   = 4'b0000;
        last_d  = last_q;
        unique case (state_q)
            StEmpty: begin
                if (capture) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (out_ready && !capture) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (capture) begin
            data_d = mux_y;
            sel_d  = nxt;
            gnt_d  = 4'b0001 << nxt;
            last_d = nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            last_q  <= RR_RESET_LAST;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign gnt       = gnt_q;

endmodule
